piso_serializer: RTL and testbench

//   Parallel-in/serial-out stage that feeds the serial sequence detectors (e.g. the 1101 Mealy detector).

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 120 ++++++++++++
 tb/tb_piso_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master side is the upstream word source and serial sink. The slave side is the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage with a valid/ready input handshake.
// It emits each WIDTH-bit word one bit per clock, and words can follow each other with no gap.
// Optional feature macro: SER_PARITY_EN adds one even-parity bit after each word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  piso_serializer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             ser_q;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  logic             last_bit;
  logic             final_cycle;
  logic             ready;
  logic             accept;
  logic             load_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // Handshake decode and bit-order selection for the load and shift paths
  always_comb begin
    last_bit    = (state == SHIFT) && (cnt == LAST);
`ifdef SER_PARITY_EN
    final_cycle = (state == PARITY);
`else
    final_cycle = last_bit;
`endif
    ready       = (state == IDLE) || final_cycle;
    accept      = bus.din_valid && ready;
    if (MSB_FIRST) begin
      load_bit   = bus.din[WIDTH-1];
      load_rest  = bus.din << 1;
      next_bit   = shreg[WIDTH-1];
      shift_rest = shreg << 1;
    end else begin
      load_bit   = bus.din[0];
      load_rest  = bus.din >> 1;
      next_bit   = shreg[0];
      shift_rest = shreg >> 1;
    end
  end

  // FSM, bit counter and shift register.
  // Accept can only occur in IDLE or in the final cycle of a word, so a load
  // takes priority over every other transition. That single check covers
  // both IDLE->SHIFT and the gapless back-to-back reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      ser_q <= 1'b0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= '0;
      shreg <= load_rest;
      ser_q <= load_bit;
`ifdef SER_PARITY_EN
      par   <= ^bus.din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (!last_bit) begin
            cnt   <= cnt + 1'b1;
            shreg <= shift_rest;
            ser_q <= next_bit;
          end else begin
`ifdef SER_PARITY_EN
            state <= PARITY;
            ser_q <= par;
`else
            state <= IDLE;
            cnt   <= '0;
            ser_q <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          state <= IDLE;
          cnt   <= '0;
          ser_q <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          ser_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready = ready;
  assign bus.ser_out   = ser_q;
  assign bus.ser_valid = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = final_cycle;
endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer. It drives an MSB-first DUT and an LSB-first DUT with the same stimulus.
// Each DUT is compared with a queue model of the bits it still has to emit.
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         vld = 1'b0;

  int checks = 0;
  int failures = 0;

  // Remaining bits to emit; the head is the bit currently on ser_out.
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bm ();
  piso_serializer_if #(.WIDTH(W)) bl ();

  assign bm.din       = din;
  assign bm.din_valid = vld;
  assign bl.din       = din;
  assign bl.din_valid = vld;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic em, el;
    em = (qm.size() > 0) ? qm[0] : 1'b0;
    el = (ql.size() > 0) ? ql[0] : 1'b0;
    chk("m.ser_out",   {31'd0, bm.ser_out},   {31'd0, em});
    chk("m.ser_valid", {31'd0, bm.ser_valid}, {31'd0, qm.size() > 0});
    chk("m.busy",      {31'd0, bm.busy},      {31'd0, qm.size() > 0});
    chk("m.done",      {31'd0, bm.done},      {31'd0, qm.size() == 1});
    chk("m.din_ready", {31'd0, bm.din_ready}, {31'd0, qm.size() <= 1});
    chk("l.ser_out",   {31'd0, bl.ser_out},   {31'd0, el});
    chk("l.ser_valid", {31'd0, bl.ser_valid}, {31'd0, ql.size() > 0});
    chk("l.done",      {31'd0, bl.done},      {31'd0, ql.size() == 1});
    chk("l.din_ready", {31'd0, bl.din_ready}, {31'd0, ql.size() <= 1});
  endtask

  // One clock: present inputs, advance the model at the edge, check at the falling edge.
  task automatic step(input logic v, input logic [W-1:0] d);
    bit acc;
    din = d;
    vld = v;
    @(posedge clk);
    acc = v && (qm.size() <= 1);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (acc) begin
      for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
      for (int i = 0; i < W; i++) ql.push_back(d[i]);
`ifdef SER_PARITY_EN
      qm.push_back(^d);
      ql.push_back(^d);
`endif
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] hist;
    int hits;

    // Reset state
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0);

    // Single MSB/LSB word (D0 / 0B patterns), then idle
    step(1'b1, 8'hD0);
    for (int i = 0; i < W + 3; i++) step(1'b0, 8'hFF);

    // 1101 detector on the LSB-first stream of 8'h0B
    hist = '0;
    hits = 0;
    step(1'b1, 8'h0B);
    for (int i = 0; i < W + 3; i++) begin
      if (bl.ser_valid) begin
        hist = {hist[2:0], bl.ser_out};
        if (hist == 4'b1101) hits++;
      end
      step(1'b0, '0);
    end
    chk("det1101_hits", hits, 1);

    // Back-to-back words with din_valid held high
    step(1'b1, 8'hA5);
    while (qm.size() > 1) step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    for (int i = 0; i < W + 3; i++) step(1'b0, '0);

    // Parity-pattern word and valid pulses while busy
    step(1'b1, 8'h07);
    step(1'b0, '0);
    step(1'b1, 8'h55);
    step(1'b0, '0);
    step(1'b1, 8'hAA);
    for (int i = 0; i < W + 3; i++) step(1'b0, '0);

    // Asynchronous reset mid-word
    step(1'b1, 8'hFF);
    step(1'b0, '0);
    step(1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) step(1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, W'($urandom));
    for (int i = 0; i < W + 4; i++) step(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
